// File: rtl/layer2_conv_scheduler.sv
// Layer-2 convolution sequencer: walks output pixels, steps the MAC
// through input channels, feeds the bias valid pipeline, then drains.
module layer2_conv_scheduler #(
  parameter int OUT_W    = 56,
  parameter int OUT_H    = 56,
  parameter int IN_CH    = 64,
  parameter int PIPE_LAT = 5,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             acc_clear,
  output logic             acc_en,
  output logic [CNT_W-1:0] ch_idx,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             valid_in_bias
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_ch;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic [DW-1:0]    r_drain;

  logic w_last_ch;
  logic w_last_col;
  logic w_last_row;
  logic w_last_pix;

  assign w_last_ch  = (r_ch == CNT_W'(IN_CH - 1));
  assign w_last_col = (r_col == CNT_W'(OUT_W - 1));
  assign w_last_row = (r_row == CNT_W'(OUT_H - 1));
  assign w_last_pix = w_last_col & w_last_row;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and output decode
  always_comb begin
    w_next        = r_state;
    busy          = 1'b1;
    done          = 1'b0;
    acc_en        = 1'b0;
    acc_clear     = 1'b0;
    valid_in_bias = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        acc_en    = ~stall;
        acc_clear = ~stall & (r_ch == '0);
        if (!stall && w_last_ch) w_next = S_BIAS;
      end
      S_BIAS: begin
        valid_in_bias = ~stall;
        if (!stall) w_next = w_last_pix ? S_DRAIN : S_ACCUM;
      end
      S_DRAIN: begin
        if (r_drain == '0) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        // A start held through completion chains straight into a new layer.
        w_next = start ? S_ACCUM : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Channel, pixel and drain counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_drain <= '0;
    end else begin
      unique case (r_state)
        S_ACCUM: begin
          if (!stall) r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
        end
        S_BIAS: begin
          if (!stall) begin
            if (w_last_pix) begin
              r_drain <= DW'(PIPE_LAT - 1);
            end else if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain != '0) r_drain <= r_drain - 1'b1;
        end
        default: begin
          r_ch    <= '0;
          r_row   <= '0;
          r_col   <= '0;
          r_drain <= '0;
        end
      endcase
    end
  end

  assign ch_idx = r_ch;
  assign row    = r_row;
  assign col    = r_col;

endmodule
